// File: rtl/sme_job_sequencer_if.sv
// sme_job_sequencer_if: host record input, SME character and
// result buses, and host result handshake in one bundle.
interface sme_job_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_kind;
  logic       in_last;
  logic [7:0] sme_chardata;
  logic       sme_isstring;
  logic       sme_ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_match_index;
  logic       res_valid;
  logic       res_ready;
  logic       res_match;
  logic [4:0] res_index;
  logic [1:0] res_status;
  logic [3:0] res_pat_id;
  logic       busy;

  modport slave (
    input  in_valid, in_data, in_kind, in_last,
    input  sme_valid, sme_match, sme_match_index,
    input  res_ready,
    output in_ready,
    output sme_chardata, sme_isstring, sme_ispattern,
    output res_valid, res_match, res_index,
    output res_status, res_pat_id, busy
  );

  modport master (
    output in_valid, in_data, in_kind, in_last,
    output sme_valid, sme_match, sme_match_index,
    output res_ready,
    input  in_ready,
    input  sme_chardata, sme_isstring, sme_ispattern,
    input  res_valid, res_match, res_index,
    input  res_status, res_pat_id, busy
  );
endinterface

// File: rtl/sme_job_sequencer.sv
// sme_job_sequencer: buffers host records, bursts them into the
// SME, waits for the match result and hands it back to the host.
module sme_job_sequencer #(
  parameter int MAXLEN  = 32,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic reset,
  sme_job_sequencer_if.slave bus
);

  localparam int LW = $clog2(MAXLEN + 1);
  localparam int AW = $clog2(MAXLEN);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAXLEN);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BURST,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  logic          r_kind;
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_rd;
  logic [TW-1:0] r_timer;
  logic          r_str_loaded;
  logic [3:0]    r_ord;
  logic [7:0]    r_buf [MAXLEN];

  logic          r_in_ready;
  logic [7:0]    r_chardata;
  logic          r_isstr;
  logic          r_ispat;
  logic          r_res_valid;
  logic          r_res_match;
  logic [4:0]    r_res_index;
  logic [1:0]    r_res_status;
  logic [3:0]    r_res_pat_id;
  logic          r_busy;

  state_t        w_state;
  logic          w_kind;
  logic [LW-1:0] w_wr_ptr;
  logic [LW-1:0] w_len;
  logic [LW-1:0] w_rd;
  logic [TW-1:0] w_timer;
  logic          w_str_loaded;
  logic [3:0]    w_ord;
  logic          w_in_ready;
  logic [7:0]    w_chardata;
  logic          w_isstr;
  logic          w_ispat;
  logic          w_res_valid;
  logic          w_res_match;
  logic [4:0]    w_res_index;
  logic [1:0]    w_res_status;
  logic [3:0]    w_res_pat_id;
  logic          w_busy;
  logic          w_we;

  logic          w_hs;
  logic          w_kind_eff;
  logic [LW-1:0] w_count;
  logic          w_end;
  logic [7:0]    w_first;
  logic [AW-1:0] w_waddr;

  // The record kind is taken only from the first byte of a record.
  assign w_hs       = bus.in_valid & r_in_ready;
  assign w_kind_eff = (r_state == S_IDLE) ? bus.in_kind : r_kind;
  assign w_count    = r_wr_ptr + 1'b1;
  assign w_end      = w_hs & (bus.in_last | (w_count == LEN_MAX));
  assign w_waddr    = r_wr_ptr[AW-1:0];
  // A one-byte record has not reached the buffer yet when it ends.
  assign w_first    = (r_wr_ptr == '0) ? bus.in_data : r_buf[0];

  // Next-state and next-output decode; every output is a flop.
  always_comb begin
    w_state      = r_state;
    w_kind       = r_kind;
    w_wr_ptr     = r_wr_ptr;
    w_len        = r_len;
    w_rd         = r_rd;
    w_timer      = r_timer;
    w_str_loaded = r_str_loaded;
    w_ord        = r_ord;
    w_chardata   = r_chardata;
    w_isstr      = 1'b0;
    w_ispat      = 1'b0;
    w_res_valid  = r_res_valid;
    w_res_match  = r_res_match;
    w_res_index  = r_res_index;
    w_res_status = r_res_status;
    w_res_pat_id = r_res_pat_id;
    w_we         = 1'b0;

    unique case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_hs) begin
          w_we     = 1'b1;
          w_wr_ptr = w_count;
          w_kind   = w_kind_eff;
          w_state  = S_LOAD;
          if (w_end) begin
            w_len    = w_count;
            w_wr_ptr = '0;
            if (w_kind_eff && !r_str_loaded) begin
              w_state      = S_RESP;
              w_res_valid  = 1'b1;
              w_res_match  = 1'b0;
              w_res_index  = '0;
              w_res_status = 2'b10;
              w_res_pat_id = r_ord;
            end else begin
              w_state    = S_BURST;
              w_chardata = w_first;
              w_isstr    = ~w_kind_eff;
              w_ispat    = w_kind_eff;
              w_rd       = LW'(1);
            end
          end
        end
      end
      S_BURST: begin
        if (r_rd == r_len) begin
          if (r_kind) begin
            w_state = S_WAIT;
            w_timer = '0;
          end else begin
            w_state      = S_IDLE;
            w_str_loaded = 1'b1;
            w_ord        = '0;
          end
        end else begin
          w_chardata = r_buf[r_rd[AW-1:0]];
          w_isstr    = ~r_kind;
          w_ispat    = r_kind;
          w_rd       = r_rd + 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.sme_valid) begin
          w_state      = S_RESP;
          w_res_valid  = 1'b1;
          w_res_match  = bus.sme_match;
          w_res_index  = bus.sme_match_index;
          w_res_status = 2'b00;
          w_res_pat_id = r_ord;
        end else if (r_timer == T_LAST) begin
          w_state      = S_RESP;
          w_res_valid  = 1'b1;
          w_res_match  = 1'b0;
          w_res_index  = '0;
          w_res_status = 2'b01;
          w_res_pat_id = r_ord;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_RESP: begin
        if (r_res_valid && bus.res_ready) begin
          w_state     = S_IDLE;
          w_res_valid = 1'b0;
          w_ord       = r_ord + 4'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_in_ready = (w_state == S_IDLE) | (w_state == S_LOAD);
    w_busy     = (w_state != S_IDLE);
  end

  // State and output registers, cleared at once by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_kind       <= 1'b0;
      r_wr_ptr     <= '0;
      r_len        <= '0;
      r_rd         <= '0;
      r_timer      <= '0;
      r_str_loaded <= 1'b0;
      r_ord        <= '0;
      r_in_ready   <= 1'b0;
      r_chardata   <= '0;
      r_isstr      <= 1'b0;
      r_ispat      <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_match  <= 1'b0;
      r_res_index  <= '0;
      r_res_status <= '0;
      r_res_pat_id <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_kind       <= w_kind;
      r_wr_ptr     <= w_wr_ptr;
      r_len        <= w_len;
      r_rd         <= w_rd;
      r_timer      <= w_timer;
      r_str_loaded <= w_str_loaded;
      r_ord        <= w_ord;
      r_in_ready   <= w_in_ready;
      r_chardata   <= w_chardata;
      r_isstr      <= w_isstr;
      r_ispat      <= w_ispat;
      r_res_valid  <= w_res_valid;
      r_res_match  <= w_res_match;
      r_res_index  <= w_res_index;
      r_res_status <= w_res_status;
      r_res_pat_id <= w_res_pat_id;
      r_busy       <= w_busy;
    end
  end

  // Record buffer; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (w_we) r_buf[w_waddr] <= bus.in_data;
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.sme_chardata  = r_chardata;
  assign bus.sme_isstring  = r_isstr;
  assign bus.sme_ispattern = r_ispat;
  assign bus.res_valid     = r_res_valid;
  assign bus.res_match     = r_res_match;
  assign bus.res_index     = r_res_index;
  assign bus.res_status    = r_res_status;
  assign bus.res_pat_id    = r_res_pat_id;
  assign bus.busy          = r_busy;

endmodule
